// File: rtl/bram_rf_burst_ctrl_if.sv
// Command, read-stream, write-stream and BRAM-port bundle of the operand BRAM burst sequencer.
// slave = the sequencer itself; master = load/store unit plus the BRAM it drives.
interface bram_rf_burst_ctrl_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LEN_W  = 6
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_wr;
  logic [ADDR_W-1:0] cmd_base;
  logic [LEN_W-1:0]  cmd_len;

  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_ready;

  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;

  logic              busy;
  logic              done;
  logic              err;

  logic [ADDR_W-1:0] addrb;
  logic [DATA_W-1:0] dinb;
  logic              enb;
  logic [3:0]        web;
  logic [DATA_W-1:0] doutb;

  modport slave (
    input  cmd_valid, cmd_wr, cmd_base, cmd_len,
    input  rd_ready, wr_data, wr_valid, doutb,
    output cmd_ready, rd_data, rd_valid, wr_ready,
    output busy, done, err,
    output addrb, dinb, enb, web
  );

  modport master (
    output cmd_valid, cmd_wr, cmd_base, cmd_len,
    output rd_ready, wr_data, wr_valid, doutb,
    input  cmd_ready, rd_data, rd_valid, wr_ready,
    input  busy, done, err,
    input  addrb, dinb, enb, web
  );
endinterface

// File: rtl/bram_rf_burst_ctrl.sv
// Burst sequencer owning the single port of the operand BRAM register file.
// Optional bounds check at command accept: define BRAM_RF_BOUNDS_CHK_EN.
module bram_rf_burst_ctrl #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DEPTH   = 48,
  parameter int unsigned LEN_W   = 6,
  parameter logic [3:0]  WR_STRB = 4'b0111
) (
  input logic                 CLK,
  input logic                 RST,
  bram_rf_burst_ctrl_if.slave bus
);

`ifdef BRAM_RF_BOUNDS_CHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_FIN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              err_q, err_d;

  logic [ADDR_W:0]   cmd_end;
  logic              cmd_oob;
  logic              bounds_bad;
  logic [ADDR_W-1:0] beat_addr;
  logic              rd_issue;
  logic              rd_hs;

  // End address is one bit wider than the bus so a base near 2^ADDR_W cannot wrap past the check
  assign cmd_end    = {1'b0, bus.cmd_base} + (ADDR_W+1)'(bus.cmd_len);
  assign cmd_oob    = (bus.cmd_len != '0) && (cmd_end > (ADDR_W+1)'(DEPTH));
  assign bounds_bad = CHK_EN && cmd_oob;

  assign beat_addr = base_q + ADDR_W'(idx_q);
  assign rd_hs     = rd_valid_q && bus.rd_ready;
  assign rd_issue  = (idx_q < len_q) && (!rd_valid_q || bus.rd_ready);

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.err      = (state_q == S_FIN) && err_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    len_d         = len_q;
    idx_d         = idx_q;
    rd_data_d     = rd_data_q;
    rd_valid_d    = rd_valid_q;
    err_d         = err_q;
    bus.cmd_ready = 1'b0;
    bus.busy      = 1'b1;
    bus.wr_ready  = 1'b0;
    bus.done      = 1'b0;
    bus.enb       = 1'b0;
    bus.web       = '0;
    bus.addrb     = '0;
    bus.dinb      = '0;

    unique case (state_q)
      S_IDLE: begin
        bus.cmd_ready = 1'b1;
        bus.busy      = 1'b0;
        if (bus.cmd_valid) begin
          base_d = bus.cmd_base;
          len_d  = bus.cmd_len;
          idx_d  = '0;
          err_d  = bounds_bad;
          if ((bus.cmd_len == '0) || bounds_bad) state_d = S_FIN;
          else if (bus.cmd_wr)                   state_d = S_WR;
          else                                   state_d = S_RD;
        end
      end

      S_RD: begin
        bus.addrb = beat_addr;
        // A new issue doubles as the handshake of the beat it replaces, so rd_valid stays high
        if (rd_issue) begin
          bus.enb    = 1'b1;
          rd_data_d  = bus.doutb;
          rd_valid_d = 1'b1;
          idx_d      = idx_q + LEN_W'(1);
        end else if (rd_hs) begin
          rd_valid_d = 1'b0;
          if (idx_q == len_q) state_d = S_FIN;
        end
      end

      S_WR: begin
        bus.wr_ready = 1'b1;
        bus.addrb    = beat_addr;
        if (bus.wr_valid) begin
          bus.enb  = 1'b1;
          bus.web  = WR_STRB;
          bus.dinb = bus.wr_data;
          idx_d    = idx_q + LEN_W'(1);
          if (idx_q == len_q - LEN_W'(1)) state_d = S_FIN;
        end
      end

      S_FIN: begin
        bus.done = 1'b1;
        err_d    = 1'b0;
        state_d  = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_bram_rf_burst_ctrl.sv
// Bench for bram_rf_burst_ctrl: directed vector table, reset abort, then random bursts
// checked against an array model of the BRAM contents and the burst timing rules.
module tb_bram_rf_burst_ctrl;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int LEN_W  = 6;
  localparam int DEPTH  = 48;
  localparam logic [3:0] WR_STRB = 4'b0111;
`ifdef BRAM_RF_BOUNDS_CHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  bram_rf_burst_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

  bram_rf_burst_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .LEN_W(LEN_W), .WR_STRB(WR_STRB)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // BRAM behaviour: 64 words so unchecked addresses past DEPTH still land somewhere visible
  logic [DATA_W-1:0] ram [64];
  logic [DATA_W-1:0] model [64];
  logic              pl_en = 1'b0;
  logic [5:0]        pl_addr = '0;
  logic [DATA_W-1:0] pl_data = '0;

  assign bus.doutb = (bus.addrb < 64) ? ram[bus.addrb[5:0]] : '0;

  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (bus.enb && bus.web == WR_STRB && bus.addrb < 64) ram[bus.addrb[5:0]] <= bus.dinb;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int done_cyc, done_cnt, err_cyc, err_cnt, enb_cnt, rdv_cnt, wrr_cnt;
  logic [DATA_W-1:0] beats[$];
  logic [ADDR_W-1:0] rd_addrs[$];
  logic [ADDR_W-1:0] wr_addrs[$];
  logic [DATA_W-1:0] wr_dats[$];
  logic              pv = 1'b0, pr = 1'b0;
  logic [DATA_W-1:0] pd = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (pv && !pr) begin
        chk("rd_hold_valid", 64'(bus.rd_valid), 64'd1);
        chk("rd_hold_data", 64'(bus.rd_data), 64'(pd));
      end
      if (bus.rd_valid && bus.rd_ready) beats.push_back(bus.rd_data);
      if (bus.rd_valid) rdv_cnt++;
      if (bus.wr_ready) wrr_cnt++;
      if (bus.done) begin done_cnt++; done_cyc = cyc; end
      if (bus.err) begin err_cnt++; err_cyc = cyc; end
      if (bus.enb) begin
        enb_cnt++;
        if (bus.web == 4'b0) rd_addrs.push_back(bus.addrb);
        else begin
          chk("web_code", 64'(bus.web), 64'(WR_STRB));
          wr_addrs.push_back(bus.addrb);
          wr_dats.push_back(bus.dinb);
        end
      end
    end
    pv = bus.rd_valid && !rst;
    pr = bus.rd_ready;
    pd = bus.rd_data;
  end

  task automatic clr();
    done_cyc = -1; done_cnt = 0; err_cyc = -1; err_cnt = 0;
    enb_cnt = 0; rdv_cnt = 0; wrr_cnt = 0;
    beats.delete(); rd_addrs.delete(); wr_addrs.delete(); wr_dats.delete();
  endtask

  // mode: 0 full throughput, 1 random ready/valid, 2 rd_ready low at T+2..T+3, 3 wr_valid gap at T+2
  task automatic run_cmd(input string nm, input bit wr, input int base, input int len, input int mode,
                         input int lat, input bit hold, input logic [31:0] d0, input logic [31:0] d1);
    logic [DATA_W-1:0] wd[$];
    int  wptr, t_acc, rel, budget;
    bit  hs, viol;
    viol = CHK_EN && (len != 0) && (base + len > DEPTH);
    for (int i = 0; i < len; i++) wd.push_back(i == 0 ? d0 : (i == 1 ? d1 : $urandom));
    wptr = 0; budget = 0;
    clr();
    bus.cmd_valid = 1'b1; bus.cmd_wr = wr;
    bus.cmd_base = ADDR_W'(base); bus.cmd_len = LEN_W'(len);
    bus.rd_ready = 1'b1; bus.wr_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_cmd_ready"}, 64'(bus.cmd_ready), 64'd1);
    t_acc = cyc;
    @(posedge clk); #1;
    if (!hold) bus.cmd_valid = 1'b0;
    while (done_cyc < 0 && budget < 300) begin
      rel = cyc - t_acc;
      case (mode)
        1:       bus.rd_ready = 1'($urandom_range(0, 1));
        2:       bus.rd_ready = !(rel == 2 || rel == 3);
        default: bus.rd_ready = 1'b1;
      endcase
      bus.wr_valid = (wptr < len) &&
                     (mode == 1 ? 1'($urandom_range(0, 1)) : (mode == 3 ? (rel != 2) : 1'b1));
      bus.wr_data  = (wptr < len) ? wd[wptr] : '0;
      @(negedge clk);
      hs = bus.wr_valid && bus.wr_ready;
      chk({nm, "_busy"}, 64'(bus.busy), 64'd1);
      if (hold) chk({nm, "_held_cmd_ready"}, 64'(bus.cmd_ready), 64'd0);
      if (mode == 2 && (rel == 2 || rel == 3)) begin
        chk({nm, "_stall_enb"}, 64'(bus.enb), 64'd0);
        chk({nm, "_stall_data"}, 64'(bus.rd_data), 64'(model[base]));
      end
      @(posedge clk); #1;
      if (hs) wptr++;
      budget++;
    end
    bus.cmd_valid = 1'b0;
    bus.wr_valid  = 1'b0;
    if (done_cyc < 0) begin
      checks++; errors++;
      $display("FAIL %s_timeout no done within %0d cycles", nm, budget);
    end
    @(negedge clk);
    chk({nm, "_idle_ready"}, 64'(bus.cmd_ready), 64'd1);
    chk({nm, "_idle_busy"}, 64'(bus.busy), 64'd0);
    chk({nm, "_done_cnt"}, 64'(done_cnt), 64'd1);
    if (lat >= 0) chk({nm, "_latency"}, 64'(done_cyc - t_acc), 64'(lat));
    if (viol) begin
      chk({nm, "_err_cyc"}, 64'(err_cyc), 64'(t_acc + 1));
      chk({nm, "_oob_enb"}, 64'(enb_cnt), 64'd0);
      chk({nm, "_oob_rdv"}, 64'(rdv_cnt), 64'd0);
      chk({nm, "_oob_wrr"}, 64'(wrr_cnt), 64'd0);
    end else begin
      chk({nm, "_err_cnt"}, 64'(err_cnt), 64'd0);
      chk({nm, "_enb_cnt"}, 64'(enb_cnt), 64'(len));
      if (len == 0) chk({nm, "_zero_streams"}, 64'(rdv_cnt + wrr_cnt), 64'd0);
      if (!wr) begin
        chk({nm, "_beats"}, 64'(beats.size()), 64'(len));
        for (int i = 0; i < len && i < beats.size(); i++)
          chk($sformatf("%s_beat%0d", nm, i), 64'(beats[i]), 64'(model[(base + i) % 64]));
        for (int i = 0; i < len && i < rd_addrs.size(); i++)
          chk($sformatf("%s_raddr%0d", nm, i), 64'(rd_addrs[i]), 64'(base + i));
      end else begin
        chk({nm, "_wbeats"}, 64'(wr_addrs.size()), 64'(len));
        for (int i = 0; i < len && i < wr_addrs.size(); i++) begin
          chk($sformatf("%s_waddr%0d", nm, i), 64'(wr_addrs[i]), 64'(base + i));
          chk($sformatf("%s_wdata%0d", nm, i), 64'(wr_dats[i]), 64'(wd[i]));
        end
        for (int i = 0; i < len; i++) model[(base + i) % 64] = wd[i];
      end
    end
    @(posedge clk); #1;
  endtask

  typedef struct {
    string       nm;
    bit          wr;
    int          base;
    int          len;
    int          mode;
    int          lat;
    bit          hold;
    logic [31:0] d0;
    logic [31:0] d1;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int e0;
    tbl[0]  = '{"rd_b0_l4",    1'b0, 0,  4, 0, 6,  1'b0, 32'h0, 32'h0};
    tbl[1]  = '{"rd_stall",    1'b0, 16, 3, 2, 7,  1'b0, 32'h0, 32'h0};
    tbl[2]  = '{"wr_gap",      1'b1, 32, 2, 3, 4,  1'b0, 32'hAAAA0001, 32'hAAAA0002};
    tbl[3]  = '{"rd_back",     1'b0, 32, 2, 0, 4,  1'b0, 32'h0, 32'h0};
    tbl[4]  = '{"rd_len0",     1'b0, 7,  0, 0, 1,  1'b1, 32'h0, 32'h0};
    tbl[5]  = '{"wr_len0",     1'b1, 9,  0, 0, 1,  1'b1, 32'h0, 32'h0};
    tbl[6]  = '{"wr_len1",     1'b1, 5,  1, 0, 2,  1'b0, 32'h12345678, 32'h0};
    tbl[7]  = '{"rd_last",     1'b0, 47, 1, 0, 3,  1'b0, 32'h0, 32'h0};
    tbl[8]  = '{"wr_top8",     1'b1, 40, 8, 0, 9,  1'b0, 32'hCAFE0000, 32'hCAFE0001};
    tbl[9]  = '{"rd_top8",     1'b0, 40, 8, 0, 10, 1'b0, 32'h0, 32'h0};
    tbl[10] = '{"rd_b46_l4",   1'b0, 46, 4, 0, CHK_EN ? 1 : 6, 1'b0, 32'h0, 32'h0};

    bus.cmd_valid = 1'b0; bus.cmd_wr = 1'b0; bus.cmd_base = '0; bus.cmd_len = '0;
    bus.rd_ready = 1'b0; bus.wr_valid = 1'b0; bus.wr_data = '0;
    clr();

    for (int i = 0; i < 64; i++) model[i] = $urandom;
    model[0] = 32'd15; model[1] = 32'd20; model[2] = 32'd42; model[3] = 32'd65;
    model[16] = 32'd48; model[17] = 32'd35; model[18] = 32'd33;
    @(posedge clk); #1;
    pl_en = 1'b1;
    for (int i = 0; i < 64; i++) begin
      pl_addr = 6'(i); pl_data = model[i];
      @(posedge clk); #1;
    end
    pl_en = 1'b0;

    chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    chk("rst_busy",      64'(bus.busy),      64'd0);
    chk("rst_wr_ready",  64'(bus.wr_ready),  64'd0);
    chk("rst_rd_valid",  64'(bus.rd_valid),  64'd0);
    chk("rst_rd_data",   64'(bus.rd_data),   64'd0);
    chk("rst_done",      64'(bus.done),      64'd0);
    chk("rst_err",       64'(bus.err),       64'd0);
    chk("rst_enb",       64'(bus.enb),       64'd0);
    chk("rst_web",       64'(bus.web),       64'd0);
    chk("rst_addrb",     64'(bus.addrb),     64'd0);
    chk("rst_dinb",      64'(bus.dinb),      64'd0);
    #2 rst = 1'b0;
    @(posedge clk); #1;

    // Reset asserted mid-cycle while a 4-word read is on its second beat
    clr();
    bus.cmd_valid = 1'b1; bus.cmd_wr = 1'b0; bus.cmd_base = '0; bus.cmd_len = LEN_W'(4);
    bus.rd_ready = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    e0 = enb_cnt;
    chk("abort_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    chk("abort_busy",      64'(bus.busy),      64'd0);
    chk("abort_rd_valid",  64'(bus.rd_valid),  64'd0);
    chk("abort_enb",       64'(bus.enb),       64'd0);
    chk("abort_web",       64'(bus.web),       64'd0);
    chk("abort_enb_before", 64'(e0), 64'd2);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("abort_no_enb",  64'(enb_cnt),  64'(e0));
    chk("abort_no_done", 64'(done_cnt), 64'd0);

    for (int i = 0; i < 11; i++)
      run_cmd(tbl[i].nm, tbl[i].wr, tbl[i].base, tbl[i].len, tbl[i].mode,
              tbl[i].lat, tbl[i].hold, tbl[i].d0, tbl[i].d1);

    for (int n = 0; n < 40; n++) begin
      bit wr;
      int len, base, mode, lat;
      wr   = 1'($urandom_range(0, 1));
      len  = int'($urandom_range(0, 10));
      base = int'($urandom_range(0, DEPTH - len));
      mode = int'($urandom_range(0, 1));
      if (mode == 0) lat = (len == 0) ? 1 : (wr ? len + 1 : len + 2);
      else           lat = -1;
      run_cmd($sformatf("rnd%0d", n), wr, base, len, mode, lat, 1'b0, $urandom, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bram_rf_burst_ctrl.md
Name: bram_rf_burst_ctrl

Overview:
Burst sequencer that owns the single port of the 48-word vector operand BRAM register file (combinational read, write on clock edge).
- Accepts one command at a time: base address, word count, direction.
- Drives addrb/dinb/enb/web word by word.
- Read data leaves on a valid/ready stream; write data arrives on a valid/ready stream.
- Sits between the SIMD load/store unit and the operand BRAM; it is the only master of that port.

Parameters:
- DATA_W, 32, data word width.
- ADDR_W, 32, BRAM address width.
- DEPTH, 48, number of BRAM words; used only by the bounds check.
- LEN_W, 6, width of the burst length field.
- WR_STRB, 4'b0111, code driven on web during a write beat; must equal the RAM's write decode.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when both cmd_valid and cmd_ready are high.
- cmd_wr  in  1  1 = write burst, 0 = read burst.
- cmd_base  in  ADDR_W  first word address.
- cmd_len  in  LEN_W  number of words; 0 is allowed.
- rd_data  out  DATA_W  read beat data.
- rd_valid  out  1  read beat valid.
- rd_ready  in  1  consumer accepts the read beat.
- wr_data  in  DATA_W  write beat data.
- wr_valid  in  1  write beat valid.
- wr_ready  out  1  controller accepts the write beat.
- busy  out  1  high in RD, WR and FIN.
- done  out  1  one-cycle pulse at command completion.
- err  out  1  bounds-violation pulse; tied 0 without the optional feature.
- addrb  out  ADDR_W  BRAM address.
- dinb  out  DATA_W  BRAM write data.
- enb  out  1  BRAM enable.
- web  out  4  BRAM write-enable code.
- doutb  in  DATA_W  BRAM read data (combinational from addrb/enb).

Behaviour:
- Reset (async, RST=1): state IDLE, idx=0, rd_valid=0, rd_data=0, done=0, err=0. Reset values of the other outputs:
  - cmd_ready=1, busy=0, wr_ready=0.
  - enb=0, web=0, addrb=0, dinb=0.
- Reset mid-burst aborts the burst immediately. Words already written stay written. No further BRAM access occurs.
- States: IDLE, RD, WR, FIN. cmd_ready=1 only in IDLE. Commands offered in any other state are ignored.
- IDLE, on accept at cycle T:
  - base, len and wr are latched; idx is cleared.
  - len=0: go to FIN.
  - Otherwise go to WR if wr=1, else RD.
- addrb = base+idx, modulo 2^ADDR_W, in RD and WR. addrb=0 in IDLE and FIN. There is no wrap at DEPTH.
- RD issue condition: idx<len and (rd_valid=0 or rd_ready=1). On an issue cycle:
  - enb=1 and web=0.
  - rd_data<=doutb, rd_valid<=1, idx++.
- RD, all other cycles: enb=0. rd_valid with a handshake and no new issue clears rd_valid.
- Read timing: first beat at T+2 (data BRAM[base]). With rd_ready held high there is one beat per cycle.
- rd_data and rd_valid hold stable while rd_valid=1 and rd_ready=0.
- RD→FIN on the cycle the last beat (idx=len) is handshaken.
- WR: wr_ready=1.
  - Cycle with wr_valid=1: enb=1, web=WR_STRB, dinb=wr_data, addrb=base+idx; the word is written at that edge; idx++.
  - Cycle with wr_valid=0: enb=0, web=0.
- WR→FIN after the beat with idx=len-1.
- FIN: done=1 for exactly one cycle, busy=1, no BRAM access, then IDLE.
- Total occupancy:
  - Read: len+2 cycles after accept at full throughput.
  - Write: len+1 cycles at full throughput.

Optional Feature:
Macro BRAM_RF_BOUNDS_CHK_EN.
- Defined: at accept, if cmd_len≠0 and cmd_base+cmd_len > DEPTH (computed at ADDR_W+1 bits), the command goes directly to FIN.
  - err=1 and done=1 in the same cycle (T+1).
  - No BRAM access, and no rd_valid or wr_ready.
- Not defined: err is tied 0 and addresses are issued unchecked.

Test Plan:
1. RST=1 asynchronously mid-clock → cmd_ready=1, busy=0, rd_valid=0, enb=0, web=0 immediately. Assert RST during a read burst of len 4 at beat 2 → no further enb and done never pulses.
2. Read base=0 len=4, rd_ready=1, BRAM[0..3]=15,20,42,65 → rd_valid at T+2..T+5 with data 15,20,42,65; done at T+6; cmd_ready=1 at T+7.
3. Read base=16 len=3, BRAM=48,35,33, rd_ready low at T+2..T+3 → rd_data=48 held; enb=0 during the stall; beats 48,35,33 each delivered exactly once.
4. Write base=32 len=2, data 0xAAAA0001 then a one-cycle wr_valid gap then 0xAAAA0002 → web=WR_STRB only on the two valid cycles at addrb 32 and 33; done one cycle after the second beat; read back returns both values.
5. cmd_len=0 (read and write) → done at T+1, enb=0 throughout, no rd_valid, wr_ready never high. A second cmd_valid held during busy is not accepted until IDLE.
6. Macro defined: base=46 len=4 → err=1 and done=1 at T+1, enb=0. Macro undefined: same command issues addrb 46,47,48,49 and err stays 0.
